// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, CDB result capture, in-order commit and mispredict flush.
// Optional build macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to the operand lookups.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 issueValid,
  input  logic [4:0]           issueDest,
  input  logic                 issueIsBranch,
  output logic [ROB_WIDTH-1:0] issueRobId,
  output logic                 robFull,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbMispredict,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic [ROB_WIDTH-1:0] robRs1Dep,
  output logic                 robRs1Ready,
  output logic [31:0]          robRs1Value,
  input  logic [ROB_WIDTH-1:0] robRs2Dep,
  output logic                 robRs2Ready,
  output logic [31:0]          robRs2Value,
  output logic                 flushOut,
  output logic [31:0]          redirectPc
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam int DATA_W = 32;
  localparam logic [ROB_WIDTH:0] FULL_CNT = {1'b1, {ROB_WIDTH{1'b0}}};

  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     ready_q;
  logic [DEPTH-1:0]     mispred_q;
  logic [DEPTH-1:0]     branch_q;
  logic [4:0]           dest_q  [DEPTH];
  logic [DATA_W-1:0]    value_q [DEPTH];

  logic commit, flush, issue_ok, cdb_wr, writes_reg;

  logic                 upd_vld_p1;
  logic [4:0]           upd_dest_p1;
  logic [DATA_W-1:0]    upd_value_p1;
  logic [ROB_WIDTH-1:0] upd_id_p1;
  logic                 flush_p1;
  logic [DATA_W-1:0]    redirect_p1;

  assign robFull    = (count == FULL_CNT);
  assign issueRobId = tail;

  // Flush on the commit edge overrides any issue or CDB write arriving with it.
  assign commit     = busy[head] && ready_q[head];
  assign flush      = commit && branch_q[head] && mispred_q[head];
  assign issue_ok   = issueValid && !robFull && !flush;
  assign cdb_wr     = cdbValid && busy[cdbRobId] && !flush;
  assign writes_reg = commit && !branch_q[head] && (dest_q[head] != 5'd0);

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      if (commit) begin
        busy[head] <= 1'b0;
        head       <= head + ROB_WIDTH'(1);
      end
      if (issue_ok) begin
        busy[tail] <= 1'b1;
        tail       <= tail + ROB_WIDTH'(1);
      end
      case ({issue_ok, commit})
        2'b10:   count <= count + (ROB_WIDTH+1)'(1);
        2'b01:   count <= count - (ROB_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload carries no reset; busy alone qualifies it.
  always_ff @(posedge clockIn) begin
    if (issue_ok) begin
      ready_q[tail]   <= 1'b0;
      mispred_q[tail] <= 1'b0;
      branch_q[tail]  <= issueIsBranch;
      dest_q[tail]    <= issueDest;
    end
    if (cdb_wr) begin
      ready_q[cdbRobId]   <= 1'b1;
      mispred_q[cdbRobId] <= cdbMispredict;
      value_q[cdbRobId]   <= cdbValue;
    end
  end

  // Stage p1: registered commit and redirect outputs, valid for one cycle after the commit edge.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      upd_vld_p1   <= 1'b0;
      upd_dest_p1  <= '0;
      upd_value_p1 <= '0;
      upd_id_p1    <= '0;
      flush_p1     <= 1'b0;
      redirect_p1  <= '0;
    end else begin
      upd_vld_p1 <= writes_reg;
      flush_p1   <= flush;
      if (writes_reg) begin
        upd_dest_p1  <= dest_q[head];
        upd_value_p1 <= value_q[head];
        upd_id_p1    <= head;
      end
      if (flush) begin
        redirect_p1 <= value_q[head];
      end
    end
  end

  assign regUpdateValid = upd_vld_p1;
  assign regUpdateDest  = upd_dest_p1;
  assign regUpdateValue = upd_value_p1;
  assign regUpdateRobId = upd_id_p1;
  assign flushOut       = flush_p1;
  assign redirectPc     = redirect_p1;

`ifdef ROB_CDB_BYPASS_EN
  logic byp1, byp2;
  assign byp1        = cdbValid && (cdbRobId == robRs1Dep) && busy[robRs1Dep];
  assign byp2        = cdbValid && (cdbRobId == robRs2Dep) && busy[robRs2Dep];
  assign robRs1Ready = byp1 || (busy[robRs1Dep] && ready_q[robRs1Dep]);
  assign robRs1Value = byp1 ? cdbValue : value_q[robRs1Dep];
  assign robRs2Ready = byp2 || (busy[robRs2Dep] && ready_q[robRs2Dep]);
  assign robRs2Value = byp2 ? cdbValue : value_q[robRs2Dep];
`else
  assign robRs1Ready = busy[robRs1Dep] && ready_q[robRs1Dep];
  assign robRs1Value = value_q[robRs1Dep];
  assign robRs2Ready = busy[robRs2Dep] && ready_q[robRs2Dep];
  assign robRs2Value = value_q[robRs2Dep];
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (ROB_WIDTH=4): reset, commit, full/wrap, out-of-order CDB, mispredict, lookup.
module tb_reorder_buffer;
  localparam int W = 4;

  logic         clockIn = 1'b0;
  logic         resetIn = 1'b0;
  logic         issueValid = 1'b0;
  logic [4:0]   issueDest = '0;
  logic         issueIsBranch = 1'b0;
  logic [W-1:0] issueRobId;
  logic         robFull;
  logic         cdbValid = 1'b0;
  logic [W-1:0] cdbRobId = '0;
  logic [31:0]  cdbValue = '0;
  logic         cdbMispredict = 1'b0;
  logic         regUpdateValid;
  logic [4:0]   regUpdateDest;
  logic [31:0]  regUpdateValue;
  logic [W-1:0] regUpdateRobId;
  logic [W-1:0] robRs1Dep = '0;
  logic         robRs1Ready;
  logic [31:0]  robRs1Value;
  logic [W-1:0] robRs2Dep = '0;
  logic         robRs2Ready;
  logic [31:0]  robRs2Value;
  logic         flushOut;
  logic [31:0]  redirectPc;

  int total = 0;
  int bad = 0;

  reorder_buffer #(.ROB_WIDTH(W)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .issueValid(issueValid), .issueDest(issueDest), .issueIsBranch(issueIsBranch),
    .issueRobId(issueRobId), .robFull(robFull),
    .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue), .cdbMispredict(cdbMispredict),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
    .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
    .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
    .flushOut(flushOut), .redirectPc(redirectPc)
  );

  always #5 clockIn = ~clockIn;

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic do_reset();
    resetIn = 1'b0;
    tick();
    resetIn = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [4:0] d, input logic br);
    issueValid = 1'b1; issueDest = d; issueIsBranch = br;
    tick();
    issueValid = 1'b0; issueIsBranch = 1'b0;
  endtask

  task automatic cdb(input logic [W-1:0] id, input logic [31:0] v, input logic mp);
    cdbValid = 1'b1; cdbRobId = id; cdbValue = v; cdbMispredict = mp;
    tick();
    cdbValid = 1'b0; cdbMispredict = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    total++; if (regUpdateValid !== 1'b0 || flushOut !== 1'b0 || redirectPc !== 32'd0) begin bad++; $display("FAIL por_outputs vld=%b flush=%b pc=%h want 0 0 0", regUpdateValid, flushOut, redirectPc); end
    resetIn = 1'b1;
    tick();
    issue(5'd1, 1'b0); issue(5'd2, 1'b0); issue(5'd3, 1'b0);
    cdb(4'd2, 32'h55, 1'b0);
    robRs1Dep = 4'd2;
    #1;
    total++; if (robRs1Ready !== 1'b1) begin bad++; $display("FAIL pre_reset_lookup ready=%b want 1", robRs1Ready); end
    total++; if (issueRobId !== 4'd3) begin bad++; $display("FAIL pre_reset_tail id=%0d want 3", issueRobId); end
    #2 resetIn = 1'b0;
    #1;
    total++; if (robFull !== 1'b0 || issueRobId !== 4'd0) begin bad++; $display("FAIL reset_ptr full=%b id=%0d want 0 0", robFull, issueRobId); end
    total++; if (robRs1Ready !== 1'b0) begin bad++; $display("FAIL reset_lookup ready=%b want 0", robRs1Ready); end
    tick();
    resetIn = 1'b1;
    tick();
    total++; if (regUpdateValid !== 1'b0 || issueRobId !== 4'd0) begin bad++; $display("FAIL reset_release vld=%b id=%0d want 0 0", regUpdateValid, issueRobId); end
  endtask

  task automatic test_commit();
    do_reset();
    issue(5'd5, 1'b0);
    cdb(4'd0, 32'h1234, 1'b0);
    total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL commit_early vld=%b want 0", regUpdateValid); end
    tick();
    total++; if (regUpdateValid !== 1'b1 || regUpdateDest !== 5'd5 || regUpdateValue !== 32'h1234 || regUpdateRobId !== 4'd0) begin
      bad++; $display("FAIL commit_out vld=%b dest=%0d val=%h id=%0d want 1 5 1234 0", regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId); end
    tick();
    total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL commit_pulse vld=%b want 0", regUpdateValid); end
    total++; if (issueRobId !== 4'd1) begin bad++; $display("FAIL commit_tail id=%0d want 1", issueRobId); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    issueValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issueDest = 5'(i + 1);
      tick();
    end
    issueValid = 1'b0;
    total++; if (robFull !== 1'b1 || issueRobId !== 4'd0) begin bad++; $display("FAIL full_set full=%b id=%0d want 1 0", robFull, issueRobId); end
    issue(5'd31, 1'b0);
    total++; if (robFull !== 1'b1 || issueRobId !== 4'd0) begin bad++; $display("FAIL full_ignore full=%b id=%0d want 1 0", robFull, issueRobId); end
    cdb(4'd0, 32'hAA, 1'b0);
    tick();
    total++; if (regUpdateValid !== 1'b1 || regUpdateRobId !== 4'd0 || regUpdateDest !== 5'd1 || regUpdateValue !== 32'hAA) begin
      bad++; $display("FAIL full_commit vld=%b id=%0d dest=%0d val=%h want 1 0 1 aa", regUpdateValid, regUpdateRobId, regUpdateDest, regUpdateValue); end
    total++; if (robFull !== 1'b0 || issueRobId !== 4'd0) begin bad++; $display("FAIL wrap_free full=%b id=%0d want 0 0", robFull, issueRobId); end
    issue(5'd9, 1'b0);
    total++; if (robFull !== 1'b1 || issueRobId !== 4'd1) begin bad++; $display("FAIL wrap_issue full=%b id=%0d want 1 1", robFull, issueRobId); end
    cdb(4'd1, 32'hBB, 1'b0);
    issueValid = 1'b1; issueDest = 5'd7;
    tick();
    issueValid = 1'b0;
    total++; if (robFull !== 1'b0 || issueRobId !== 4'd1) begin bad++; $display("FAIL full_issue_commit full=%b id=%0d want 0 1", robFull, issueRobId); end
    total++; if (regUpdateValid !== 1'b1 || regUpdateRobId !== 4'd1 || regUpdateValue !== 32'hBB) begin
      bad++; $display("FAIL full_commit2 vld=%b id=%0d val=%h want 1 1 bb", regUpdateValid, regUpdateRobId, regUpdateValue); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    issue(5'd1, 1'b0); issue(5'd2, 1'b0);
    cdb(4'd1, 32'h22, 1'b0);
    cdb(4'd0, 32'h11, 1'b0);
    total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL ooo_hold vld=%b want 0", regUpdateValid); end
    tick();
    total++; if (regUpdateValid !== 1'b1 || regUpdateRobId !== 4'd0 || regUpdateDest !== 5'd1 || regUpdateValue !== 32'h11) begin
      bad++; $display("FAIL ooo_first vld=%b id=%0d dest=%0d val=%h want 1 0 1 11", regUpdateValid, regUpdateRobId, regUpdateDest, regUpdateValue); end
    tick();
    total++; if (regUpdateValid !== 1'b1 || regUpdateRobId !== 4'd1 || regUpdateDest !== 5'd2 || regUpdateValue !== 32'h22) begin
      bad++; $display("FAIL ooo_second vld=%b id=%0d dest=%0d val=%h want 1 1 2 22", regUpdateValid, regUpdateRobId, regUpdateDest, regUpdateValue); end
    tick();
    total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL ooo_done vld=%b want 0", regUpdateValid); end
  endtask

  task automatic test_mispredict();
    do_reset();
    issue(5'd0, 1'b1); issue(5'd3, 1'b0); issue(5'd4, 1'b0);
    cdb(4'd1, 32'h33, 1'b0);
    cdb(4'd0, 32'h80, 1'b1);
    issueValid = 1'b1; issueDest = 5'd9;
    tick();
    issueValid = 1'b0;
    total++; if (flushOut !== 1'b1 || redirectPc !== 32'h80) begin bad++; $display("FAIL flush_out flush=%b pc=%h want 1 80", flushOut, redirectPc); end
    total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL flush_no_write vld=%b want 0", regUpdateValid); end
    total++; if (issueRobId !== 4'd0 || robFull !== 1'b0) begin bad++; $display("FAIL flush_ptr id=%0d full=%b want 0 0", issueRobId, robFull); end
    robRs1Dep = 4'd1;
    #1;
    total++; if (robRs1Ready !== 1'b0) begin bad++; $display("FAIL flush_busy ready=%b want 0", robRs1Ready); end
    tick();
    total++; if (flushOut !== 1'b0) begin bad++; $display("FAIL flush_pulse flush=%b want 0", flushOut); end
    for (int i = 0; i < 3; i++) begin
      total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL flush_stale_commit cyc=%0d vld=%b want 0", i, regUpdateValid); end
      tick();
    end
  endtask

  task automatic test_lookup();
    logic exp_byp;
`ifdef ROB_CDB_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    do_reset();
    issue(5'd1, 1'b0); issue(5'd2, 1'b0); issue(5'd3, 1'b0); issue(5'd4, 1'b0);
    robRs1Dep = 4'd3; robRs2Dep = 4'd3;
    cdbValid = 1'b1; cdbRobId = 4'd3; cdbValue = 32'd7; cdbMispredict = 1'b0;
    #1;
    total++; if (robRs1Ready !== exp_byp) begin bad++; $display("FAIL lookup_same_cycle ready=%b want %b", robRs1Ready, exp_byp); end
    if (exp_byp) begin
      total++; if (robRs1Value !== 32'd7) begin bad++; $display("FAIL lookup_bypass_val val=%h want 7", robRs1Value); end
    end
    tick();
    cdbValid = 1'b0;
    #1;
    total++; if (robRs1Ready !== 1'b1 || robRs1Value !== 32'd7) begin bad++; $display("FAIL lookup_rs1 ready=%b val=%h want 1 7", robRs1Ready, robRs1Value); end
    total++; if (robRs2Ready !== 1'b1 || robRs2Value !== 32'd7) begin bad++; $display("FAIL lookup_rs2 ready=%b val=%h want 1 7", robRs2Ready, robRs2Value); end
    cdb(4'd9, 32'h99, 1'b0);
    robRs2Dep = 4'd9;
    #1;
    total++; if (robRs2Ready !== 1'b0) begin bad++; $display("FAIL cdb_non_busy ready=%b want 0", robRs2Ready); end
    total++; if (regUpdateValid !== 1'b0) begin bad++; $display("FAIL lookup_no_commit vld=%b want 0", regUpdateValid); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_full_wrap();
    test_out_of_order();
    test_mispredict();
    test_lookup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
